// File: rtl/bloom_bram_mp.sv
// True dual-port bit-array RAM for the bloom filter. It has byte-lane writes, a port-A-wins
// collision policy, and a clear engine that zeroes the array after reset or on request.
module bloom_bram_mp #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int BE_WIDTH       = 2,
    parameter int OUT_REG        = 1,
    parameter int WRITE_FIRST    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  en_a,
    input  logic [BE_WIDTH-1:0]   we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  rvalid_a,
    input  logic                  en_b,
    input  logic [BE_WIDTH-1:0]   we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  rvalid_b,
    output logic                  collision
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int LANE_W = DATA_WIDTH / BE_WIDTH;

    localparam logic [0:0] IDLE        = 1'b0;
    localparam logic [0:0] CLEAR       = 1'b1;
    localparam logic [0:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  acc_a, acc_b;
    logic [DATA_WIDTH-1:0] ret_a, ret_b;
    logic [DATA_WIDTH-1:0] q1_a, q1_b;
    logic                  v1_a, v1_b;

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   we
    );
        lane_merge = old_word;
        for (int i = 0; i < BE_WIDTH; i++)
            if (we[i]) lane_merge[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
    endfunction

    assign busy  = (state == CLEAR);
    assign acc_a = rst_n && en_a && (state == IDLE);
    assign acc_b = rst_n && en_b && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) state <= IDLE;
        end else if (clear_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end
    end

    // Port A's lane writes come last so they win on lanes that both ports write.
    always_ff @(posedge clk) begin
        if (rst_n && state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < BE_WIDTH; i++)
                if (acc_b && we_b[i]) mem[addr_b][i*LANE_W +: LANE_W] <= din_b[i*LANE_W +: LANE_W];
            for (int i = 0; i < BE_WIDTH; i++)
                if (acc_a && we_a[i]) mem[addr_a][i*LANE_W +: LANE_W] <= din_a[i*LANE_W +: LANE_W];
        end
    end

    // Each port sees the pre-cycle word, overlaid only with its own lanes in write-first mode.
    assign ret_a = (WRITE_FIRST != 0) ? lane_merge(mem[addr_a], din_a, we_a) : mem[addr_a];
    assign ret_b = (WRITE_FIRST != 0) ? lane_merge(mem[addr_b], din_b, we_b) : mem[addr_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            q1_a      <= '0;
            q1_b      <= '0;
            collision <= 1'b0;
        end else begin
            v1_a      <= acc_a;
            v1_b      <= acc_b;
            if (acc_a) q1_a <= ret_a;
            if (acc_b) q1_b <= ret_b;
            collision <= acc_a && acc_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_a, q2_b;
            logic                  v2_a, v2_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                    q2_a <= '0;
                    q2_b <= '0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) q2_a <= q1_a;
                    if (v1_b) q2_b <= q1_b;
                end
            end

            assign dout_a   = q2_a;
            assign dout_b   = q2_b;
            assign rvalid_a = v2_a;
            assign rvalid_b = v2_b;
        end else begin : g_no_out_reg
            assign dout_a   = q1_a;
            assign dout_b   = q1_b;
            assign rvalid_a = v1_a;
            assign rvalid_b = v1_b;
        end
    endgenerate
endmodule

// File: tb/tb_bloom_bram_mp.sv
// Scoreboard bench for bloom_bram_mp: two instances (registered/write-first and
// unregistered/read-first) share stimulus and are checked against a reference array.
module tb_bloom_bram_mp;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int BW    = 2;
    localparam int LW    = DW / BW;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear_req = 1'b0;
    logic          en_a = 1'b0, en_b = 1'b0;
    logic [BW-1:0] we_a = '0, we_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;

    logic [DW-1:0] dout_a1, dout_b1, dout_a0, dout_b0;
    logic          rvalid_a1, rvalid_b1, rvalid_a0, rvalid_b0;
    logic          busy1, busy0, coll1, coll0;

    exp_t          exp_q [4][$];
    logic [DW-1:0] ref_mem [DEPTH];
    string         pname [4] = '{"dout_a(reg,wf)", "dout_b(reg,wf)", "dout_a(noreg,rf)", "dout_b(noreg,rf)"};
    int            clr_cnt = DEPTH;
    int            cyc = 0;
    logic          exp_coll = 1'b0;
    int            checks = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    bloom_bram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .OUT_REG(1),
                    .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) d1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .rvalid_a(rvalid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .rvalid_b(rvalid_b1),
        .collision(coll1));

    bloom_bram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .OUT_REG(0),
                    .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) d0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .rvalid_a(rvalid_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .rvalid_b(rvalid_b0),
        .collision(coll0));

    function automatic logic [DW-1:0] lane_mix(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                               input logic [BW-1:0] we);
        lane_mix = old_w;
        for (int i = 0; i < BW; i++)
            if (we[i]) lane_mix[i*LW +: LW] = new_w[i*LW +: LW];
    endfunction

    task automatic idle_inputs();
        en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0; clear_req = 1'b0;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 4; p++) exp_q[p].delete();
        clr_cnt  = DEPTH;
        exp_coll = 1'b0;
    endtask

    // Advance one clock and update the reference model with the inputs applied at that edge.
    task automatic step();
        logic          idle;
        logic [DW-1:0] pre_a, pre_b;
        exp_t          e;
        @(posedge clk);
        #1;
        cyc++;
        exp_coll = 1'b0;
        if (rst_n) begin
            idle = (clr_cnt == 0);
            if (!idle) begin
                ref_mem[DEPTH - clr_cnt] = '0;
                clr_cnt--;
            end else begin
                pre_a = ref_mem[addr_a];
                pre_b = ref_mem[addr_b];
                if (en_a) begin
                    e.data = lane_mix(pre_a, din_a, we_a); e.cyc = cyc + 1; exp_q[0].push_back(e);
                    e.data = pre_a;                        e.cyc = cyc;     exp_q[2].push_back(e);
                end
                if (en_b) begin
                    e.data = lane_mix(pre_b, din_b, we_b); e.cyc = cyc + 1; exp_q[1].push_back(e);
                    e.data = pre_b;                        e.cyc = cyc;     exp_q[3].push_back(e);
                end
                exp_coll = en_a && en_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
                for (int i = 0; i < BW; i++)
                    if (en_b && we_b[i]) ref_mem[addr_b][i*LW +: LW] = din_b[i*LW +: LW];
                for (int i = 0; i < BW; i++)
                    if (en_a && we_a[i]) ref_mem[addr_a][i*LW +: LW] = din_a[i*LW +: LW];
                if (clear_req) clr_cnt = DEPTH;
            end
        end
    endtask

    task automatic count_busy(output int n, input logic second_req);
        n = 0;
        while (busy1 && n < 40) begin
            n++;
            clear_req = second_req && (n == 4);
            step();
        end
        clear_req = 1'b0;
    endtask

    // Scoreboard consumer: every rvalid pops one expectation; busy and collision follow the model.
    always @(negedge clk) begin
        logic [DW-1:0] dv [4];
        logic          rv [4];
        exp_t          e;
        dv[0] = dout_a1; dv[1] = dout_b1; dv[2] = dout_a0; dv[3] = dout_b0;
        rv[0] = rvalid_a1; rv[1] = rvalid_b1; rv[2] = rvalid_a0; rv[3] = rvalid_b0;
        for (int p = 0; p < 4; p++) begin
            if (rv[p]) begin
                checks++;
                if (exp_q[p].size() == 0) begin
                    $display("[TB] FAIL %s: rvalid with %h at cycle %0d, expected no rvalid", pname[p], dv[p], cyc);
                end else begin
                    e = exp_q[p].pop_front();
                    if (dv[p] !== e.data || cyc != e.cyc)
                        $display("[TB] FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                                 pname[p], dv[p], cyc, e.data, e.cyc);
                    else passed++;
                end
            end else if (exp_q[p].size() != 0 && exp_q[p][0].cyc <= cyc) begin
                checks++;
                e = exp_q[p].pop_front();
                $display("[TB] FAIL %s: no rvalid at cycle %0d, expected %h at cycle %0d", pname[p], cyc, e.data, e.cyc);
            end
        end
        checks++;
        if (busy1 !== (clr_cnt > 0) || busy0 !== (clr_cnt > 0))
            $display("[TB] FAIL busy: got %b/%b at cycle %0d, expected %b", busy1, busy0, cyc, clr_cnt > 0);
        else passed++;
        checks++;
        if (coll1 !== exp_coll || coll0 !== exp_coll)
            $display("[TB] FAIL collision: got %b/%b at cycle %0d, expected %b", coll1, coll0, cyc, exp_coll);
        else passed++;
    end

    task automatic test_reset();
        int n;
        #2;
        assert_reset();
        #1;
        checks++;
        if (busy1 !== 1'b1 || busy0 !== 1'b1) $display("[TB] FAIL reset_busy: got %b/%b, expected 1", busy1, busy0);
        else passed++;
        checks++;
        if ({rvalid_a1, rvalid_b1, rvalid_a0, rvalid_b0} !== 4'b0000)
            $display("[TB] FAIL reset_rvalid: got %b%b%b%b, expected 0000", rvalid_a1, rvalid_b1, rvalid_a0, rvalid_b0);
        else passed++;
        checks++;
        if (dout_a1 !== 16'h0 || dout_b1 !== 16'h0 || dout_a0 !== 16'h0 || dout_b0 !== 16'h0)
            $display("[TB] FAIL reset_dout: got %h %h %h %h, expected 0000", dout_a1, dout_b1, dout_a0, dout_b0);
        else passed++;
        checks++;
        if (coll1 !== 1'b0 || coll0 !== 1'b0) $display("[TB] FAIL reset_collision: got %b/%b, expected 0", coll1, coll0);
        else passed++;
        step(); step();
        rst_n = 1'b1;
        count_busy(n, 1'b0);
        checks++;
        if (n != DEPTH) $display("[TB] FAIL reset_sweep_len: got %0d cycles, expected %0d", n, DEPTH);
        else passed++;
    endtask

    task automatic test_reset_sweep();
        int n;
        for (int i = 0; i < DEPTH; i += 2) begin
            en_a = 1'b1; we_a = 2'b11; addr_a = AW'(i);     din_a = 16'hFFFF;
            en_b = 1'b1; we_b = 2'b11; addr_b = AW'(i + 1); din_b = 16'hFFFF;
            step();
        end
        idle_inputs();
        assert_reset();
        step();
        en_a = 1'b1; addr_a = 4'd1; en_b = 1'b1; addr_b = 4'd2;
        rst_n = 1'b1;
        count_busy(n, 1'b0);
        checks++;
        if (n != DEPTH) $display("[TB] FAIL prefill_sweep_len: got %0d cycles, expected %0d", n, DEPTH);
        else passed++;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; addr_a = AW'(i); en_b = 1'b1; addr_b = AW'(DEPTH - 1 - i);
            step();
        end
        idle_inputs();
        step(); step();
        checks++;
        if (dout_a1 !== 16'h0000 || dout_b0 !== 16'h0000)
            $display("[TB] FAIL swept_word: got %h/%h, expected 0000", dout_a1, dout_b0);
        else passed++;
    endtask

    task automatic test_byte_lanes();
        en_a = 1'b1; we_a = 2'b11; addr_a = 4'd3; din_a = 16'hABCD; step();
        we_a = 2'b01; din_a = 16'h0012; step();
        we_a = 2'b00; en_b = 1'b1; addr_b = 4'd3; step();
        idle_inputs();
        step();
        checks++;
        if (dout_a1 !== 16'hAB12 || dout_a0 !== 16'hAB12 || dout_b1 !== 16'hAB12)
            $display("[TB] FAIL byte_lanes: got %h/%h/%h, expected ab12", dout_a1, dout_a0, dout_b1);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; we_a = 2'b11; addr_a = AW'(i); din_a = DW'(16'h1000 + i * 273);
            step();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; addr_a = AW'(i); en_b = 1'b1; addr_b = AW'(DEPTH - 1 - i);
            step();
        end
        idle_inputs();
        step(); step(); step();
        checks++;
        if (rvalid_a1 !== 1'b0 || dout_a1 !== DW'(16'h1000 + 15 * 273) || dout_b1 !== 16'h1000)
            $display("[TB] FAIL hold_dout: got %h/%h rvalid %b, expected %h/1000 rvalid 0",
                     dout_a1, dout_b1, rvalid_a1, DW'(16'h1000 + 15 * 273));
        else passed++;
    endtask

    task automatic test_collision();
        en_a = 1'b1; we_a = 2'b11; addr_a = 4'd5; din_a = 16'h1111;
        en_b = 1'b1; we_b = 2'b11; addr_b = 4'd5; din_b = 16'h2222;
        step();
        checks++;
        if (coll1 !== 1'b1 || coll0 !== 1'b1) $display("[TB] FAIL coll_ww: got %b/%b, expected 1", coll1, coll0);
        else passed++;
        we_a = 2'b00; we_b = 2'b00;
        step();
        checks++;
        if (coll1 !== 1'b0 || coll0 !== 1'b0) $display("[TB] FAIL coll_rr: got %b/%b, expected 0", coll1, coll0);
        else passed++;
        idle_inputs();
        step();
        checks++;
        if (dout_a1 !== 16'h1111 || dout_b1 !== 16'h1111)
            $display("[TB] FAIL coll_a_wins: got %h/%h, expected 1111", dout_a1, dout_b1);
        else passed++;
        en_a = 1'b1; we_a = 2'b01; din_a = 16'h2211;
        en_b = 1'b1; we_b = 2'b10; din_b = 16'h2211;
        step();
        idle_inputs();
        en_a = 1'b1; step();
        idle_inputs();
        step();
        checks++;
        if (dout_a1 !== 16'h2211) $display("[TB] FAIL coll_lanes: got %h, expected 2211", dout_a1);
        else passed++;
        en_a = 1'b1; we_a = 2'b11; din_a = 16'h5A5A; en_b = 1'b1; we_b = 2'b00;
        step();
        idle_inputs();
        step();
        checks++;
        if (dout_b1 !== 16'h2211 || dout_b0 !== 16'h2211 || dout_a0 !== 16'h2211 || dout_a1 !== 16'h5A5A)
            $display("[TB] FAIL coll_old_word: got b %h/%h a %h/%h, expected b 2211/2211 a 5a5a/2211",
                     dout_b1, dout_b0, dout_a1, dout_a0);
        else passed++;
    endtask

    task automatic test_mode();
        en_a = 1'b1; we_a = 2'b11; addr_a = 4'd7; din_a = 16'h00FF; step();
        din_a = 16'h1234; step();
        idle_inputs();
        step();
        checks++;
        if (dout_a1 !== 16'h1234 || dout_a0 !== 16'h00FF)
            $display("[TB] FAIL write_mode: got wf %h rf %h, expected wf 1234 rf 00ff", dout_a1, dout_a0);
        else passed++;
    endtask

    task automatic test_clear();
        int n;
        en_a = 1'b1; we_a = 2'b11; addr_a = 4'd2; din_a = 16'hBEEF; step();
        clear_req = 1'b1; we_a = 2'b00;
        en_b = 1'b1; we_b = 2'b11; addr_b = 4'd4; din_b = 16'hCAFE;
        step();
        clear_req = 1'b0; we_b = 2'b00; addr_b = 4'd2;
        count_busy(n, 1'b1);
        checks++;
        if (n != DEPTH) $display("[TB] FAIL clear_len: got %0d cycles, expected %0d", n, DEPTH);
        else passed++;
        idle_inputs();
        en_a = 1'b1; addr_a = 4'd2; en_b = 1'b1; addr_b = 4'd4; step();
        idle_inputs();
        en_a = 1'b1; we_a = 2'b11; addr_a = 4'd9; din_a = 16'h9999; step();
        idle_inputs();
        clear_req = 1'b1; step();
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        assert_reset();
        step();
        rst_n = 1'b1;
        count_busy(n, 1'b0);
        checks++;
        if (n != DEPTH) $display("[TB] FAIL restart_len: got %0d cycles, expected %0d", n, DEPTH);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; addr_a = AW'(i); en_b = 1'b1; addr_b = AW'(i);
            step();
        end
        idle_inputs();
        step(); step(); step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_reset_sweep();
        test_byte_lanes();
        test_back_to_back();
        test_collision();
        test_mode();
        test_clear();
        checks++;
        if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0)
            $display("[TB] FAIL drained: got %0d outstanding, expected 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
